rpll_reconfig_ctrl: RTL and testbench

//  Run-time manager for the Gowin rPLL feeding the DDR3 controller. Drives the dynamic IDSEL/FBDSEL/ODSEL

---
 rtl/rpll_ctrl_pkg.sv | 48 ++++
 rtl/pll_lock_sync.sv | 21 ++
 rtl/rpll_reconfig_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_rpll_reconfig_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpll_ctrl_pkg.sv
// Shared types, preset table layout and default rPLL preset table for the
// rPLL run-time reconfiguration controller.
package rpll_ctrl_pkg;

  typedef enum logic [2:0] {
    APPLY,
    HOLD,
    WAIT_LOCK,
    STABLE,
    FAIL,
    RUN
  } state_t;

  localparam int MAX_PRESETS = 16;
  localparam int FIELD_W     = 6;
  localparam int ENTRY_W     = 3 * FIELD_W;
  localparam int IDSEL_OFF   = 2 * FIELD_W;
  localparam int FBDSEL_OFF  = FIELD_W;
  localparam int ODSEL_OFF   = 0;
  localparam int TABLE_W     = MAX_PRESETS * ENTRY_W;

  typedef struct packed {
    logic [FIELD_W-1:0] idsel;
    logic [FIELD_W-1:0] fbdsel;
    logic [FIELD_W-1:0] odsel;
  } preset_t;

  // Raw dynamic codes are 64 - divider: {IDSEL, FBDSEL, ODSEL} from 27 MHz
  localparam logic [ENTRY_W-1:0] PRESET_398M25 = {6'd60, 6'd5,  6'd62}; // /4 x59 /2
  localparam logic [ENTRY_W-1:0] PRESET_297M   = {6'd63, 6'd53, 6'd62}; // /1 x11 /2
  localparam logic [ENTRY_W-1:0] PRESET_351M   = {6'd63, 6'd51, 6'd62}; // /1 x13 /2
  localparam logic [ENTRY_W-1:0] PRESET_405M   = {6'd63, 6'd49, 6'd62}; // /1 x15 /2

  // Table is always MAX_PRESETS wide; only the first NUM_PRESETS entries are reachable
  localparam logic [TABLE_W-1:0] DEF_PRESET_TABLE =
    {{(MAX_PRESETS - 4){PRESET_398M25}}, PRESET_405M, PRESET_351M, PRESET_297M, PRESET_398M25};

  function automatic preset_t preset_fields(input logic [TABLE_W-1:0] tbl, input int unsigned idx);
    logic [ENTRY_W-1:0] entry;
    preset_t            p;
    entry    = tbl[(idx % MAX_PRESETS) * ENTRY_W +: ENTRY_W];
    p.idsel  = entry[IDSEL_OFF  +: FIELD_W];
    p.fbdsel = entry[FBDSEL_OFF +: FIELD_W];
    p.odsel  = entry[ODSEL_OFF  +: FIELD_W];
    return p;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous rPLL LOCK into the board clock domain.
module pll_lock_sync (
  input  logic clk,
  input  logic resetn,
  input  logic lock_async,
  output logic lock_s
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], lock_async};
    end
  end

  assign lock_s = sync_reg[1];

endmodule

// File: rtl/rpll_reconfig_ctrl.sv
// rPLL run-time manager: programs IDSEL/FBDSEL/ODSEL from a preset table and sequences
// PLL reset, lock wait, lock debounce, retry/fallback and downstream reset release.
module rpll_reconfig_ctrl
  import rpll_ctrl_pkg::*;
#(
  parameter int                 NUM_PRESETS      = 4,
  parameter logic [TABLE_W-1:0] PRESET_TABLE     = DEF_PRESET_TABLE,
  parameter int                 DEFAULT_PRESET   = 0,
  parameter int                 RST_HOLD_CYC     = 16,
  parameter int                 LOCK_TIMEOUT_CYC = 65535,
  parameter int                 LOCK_STABLE_CYC  = 1024,
  parameter int                 MAX_RETRY        = 3,
  // May be widened so that out-of-range indices can be presented on req_preset
  parameter int                 PW               = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req_valid,
  input  logic [PW-1:0] req_preset,
  output logic          req_ready,
  output logic          bad_req,
  input  logic          pll_lock,
  output logic          pll_reset,
  output logic [5:0]    idsel,
  output logic [5:0]    fbdsel,
  output logic [5:0]    odsel,
  output logic [PW-1:0] active_preset,
  output logic          clk_ok,
  output logic          sys_resetn,
  output logic          busy,
  output logic          err_fallback,
  output logic [7:0]    lock_loss_cnt
);

  localparam int CNT_MAX =
    (LOCK_TIMEOUT_CYC > RST_HOLD_CYC)
      ? ((LOCK_TIMEOUT_CYC > LOCK_STABLE_CYC) ? LOCK_TIMEOUT_CYC : LOCK_STABLE_CYC)
      : ((RST_HOLD_CYC > LOCK_STABLE_CYC) ? RST_HOLD_CYC : LOCK_STABLE_CYC);
  localparam int            CW         = $clog2(CNT_MAX) + 1;
  localparam int            RW         = $clog2(MAX_RETRY) + 1;
  localparam logic [PW-1:0] DEF_IDX    = PW'(DEFAULT_PRESET);
  localparam preset_t       DEF_FIELDS = preset_fields(PRESET_TABLE, DEFAULT_PRESET);

  logic lock_s;

  pll_lock_sync u_lock_sync (
    .clk        (clk),
    .resetn     (resetn),
    .lock_async (pll_lock),
    .lock_s     (lock_s)
  );

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [RW-1:0] retry_reg, retry_next;
  logic [PW-1:0] target_reg, target_next;
  logic [PW-1:0] active_reg;
  preset_t       div_reg;
  logic          err_reg, err_next;
  logic [7:0]    loss_reg, loss_next;
  logic          bad_req_reg, bad_req_next;
  logic          load_div;
  logic          pll_reset_reg, clk_ok_reg, sys_resetn_reg, req_ready_reg, busy_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    retry_next   = retry_reg;
    target_next  = target_reg;
    err_next     = err_reg;
    loss_next    = loss_reg;
    bad_req_next = 1'b0;
    load_div     = 1'b0;
    case (state_reg)
      APPLY: begin
        load_div   = 1'b1;
        state_next = HOLD;
        cnt_next   = '0;
      end
      HOLD: begin
        if (cnt_reg == CW'(RST_HOLD_CYC - 1)) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          // The cycle that first saw lock_s high is the first debounced cycle
          state_next = STABLE;
          cnt_next   = CW'(1);
        end else if (cnt_reg == CW'(LOCK_TIMEOUT_CYC - 1)) begin
          state_next = FAIL;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_next = FAIL;
          cnt_next   = '0;
        end else if (cnt_reg >= CW'(LOCK_STABLE_CYC - 1)) begin
          state_next = RUN;
          cnt_next   = '0;
          retry_next = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      FAIL: begin
        state_next = APPLY;
        if (int'(retry_reg) + 1 < MAX_RETRY) begin
          retry_next = retry_reg + RW'(1);
        end else begin
          retry_next  = '0;
          target_next = DEF_IDX;
          err_next    = 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_next  = APPLY;
          target_next = active_reg;
          if (loss_reg != 8'hFF) loss_next = loss_reg + 8'd1;
        end else if (req_valid && req_ready) begin
          if (int'(req_preset) < NUM_PRESETS) begin
            state_next  = APPLY;
            target_next = req_preset;
          end else begin
            bad_req_next = 1'b1;
          end
        end
      end
      default: state_next = APPLY;
    endcase
  end

  // Outputs are decoded from state_next so they change on the same edge as the state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= APPLY;
      cnt_reg        <= '0;
      retry_reg      <= '0;
      target_reg     <= DEF_IDX;
      active_reg     <= DEF_IDX;
      div_reg        <= DEF_FIELDS;
      err_reg        <= 1'b0;
      loss_reg       <= '0;
      bad_req_reg    <= 1'b0;
      pll_reset_reg  <= 1'b1;
      clk_ok_reg     <= 1'b0;
      sys_resetn_reg <= 1'b0;
      req_ready_reg  <= 1'b0;
      busy_reg       <= 1'b1;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      retry_reg      <= retry_next;
      target_reg     <= target_next;
      err_reg        <= err_next;
      loss_reg       <= loss_next;
      bad_req_reg    <= bad_req_next;
      if (load_div) begin
        div_reg    <= preset_fields(PRESET_TABLE, int'(target_reg));
        active_reg <= target_reg;
      end
      pll_reset_reg  <= !(state_next inside {WAIT_LOCK, STABLE, RUN});
      clk_ok_reg     <= (state_next == RUN);
      sys_resetn_reg <= (state_next == RUN);
      req_ready_reg  <= (state_next == RUN);
      busy_reg       <= (state_next != RUN);
    end
  end

  // Gating with lock_s keeps a request from being accepted in the lock-loss cycle
  assign req_ready     = req_ready_reg & lock_s;
  assign bad_req       = bad_req_reg;
  assign pll_reset     = pll_reset_reg;
  assign idsel         = div_reg.idsel;
  assign fbdsel        = div_reg.fbdsel;
  assign odsel         = div_reg.odsel;
  assign active_preset = active_reg;
  assign clk_ok        = clk_ok_reg;
  assign sys_resetn    = sys_resetn_reg;
  assign busy          = busy_reg;
  assign err_fallback  = err_reg;
  assign lock_loss_cnt = loss_reg;

endmodule

// File: tb/tb_rpll_reconfig_ctrl.sv
// Directed bench for rpll_reconfig_ctrl: boot, preset change, bad index, lock loss,
// timeout fallback, STABLE glitch retry and asynchronous reset mid-sequence.
module tb_rpll_reconfig_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req_valid;
  logic [2:0] req_preset;
  logic       req_ready;
  logic       bad_req;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] idsel, fbdsel, odsel;
  logic [2:0] active_preset;
  logic       clk_ok;
  logic       sys_resetn;
  logic       busy;
  logic       err_fallback;
  logic [7:0] lock_loss_cnt;
  logic [17:0] div;

  localparam logic [17:0] E0 = {6'd60, 6'd5,  6'd62};
  localparam logic [17:0] E1 = {6'd63, 6'd53, 6'd62};
  localparam logic [17:0] E2 = {6'd63, 6'd51, 6'd62};
  localparam logic [17:0] E3 = {6'd63, 6'd49, 6'd62};

  always #5 clk = ~clk;
  assign div = {idsel, fbdsel, odsel};

  rpll_reconfig_ctrl #(
    .NUM_PRESETS      (4),
    .DEFAULT_PRESET   (0),
    .RST_HOLD_CYC     (4),
    .LOCK_TIMEOUT_CYC (100),
    .LOCK_STABLE_CYC  (8),
    .MAX_RETRY        (2),
    .PW               (3)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_preset    (req_preset),
    .req_ready     (req_ready),
    .bad_req       (bad_req),
    .pll_lock      (pll_lock),
    .pll_reset     (pll_reset),
    .idsel         (idsel),
    .fbdsel        (fbdsel),
    .odsel         (odsel),
    .active_preset (active_preset),
    .clk_ok        (clk_ok),
    .sys_resetn    (sys_resetn),
    .busy          (busy),
    .err_fallback  (err_fallback),
    .lock_loss_cnt (lock_loss_cnt)
  );

  typedef struct {
    logic        req_valid;
    logic [2:0]  req_preset;
    logic        exp_ready;
    logic        exp_bad;
    logic        exp_busy;
    logic        exp_pll_reset;
    logic [17:0] exp_div;
    logic [2:0]  exp_active;
  } vec_t;

  vec_t vecs[6];
  int   n_vec = 0;
  int   n_err = 0;
  int   k, hi, lo;
  logic div_ok, saw;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_run(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && clk_ok !== 1'b1) begin
      tick();
      n++;
    end
    $display("%s: clk_ok after %0d cycles", name, n);
    check(name, clk_ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_preset = 3'd0;
    pll_lock   = 1'b0;

    //            valid preset ready bad busy prst div active
    vecs[0] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, E0, 3'd0};
    vecs[1] = '{1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, E0, 3'd0};
    vecs[2] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, E0, 3'd0};
    vecs[3] = '{1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, E0, 3'd0};
    vecs[4] = '{1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, E2, 3'd2};
    vecs[5] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, E2, 3'd2};

    repeat (3) tick();
    check("rst pll_reset", pll_reset, 1);
    check("rst sys_resetn", sys_resetn, 0);
    check("rst clk_ok", clk_ok, 0);
    check("rst req_ready", req_ready, 0);
    check("rst bad_req", bad_req, 0);
    check("rst busy", busy, 1);
    check("rst dividers", div, E0);
    check("rst active", active_preset, 0);
    check("rst err_fallback", err_fallback, 0);
    check("rst lock_loss", lock_loss_cnt, 0);

    // Boot: pll_reset width, then lock 20 cycles after pll_reset falls
    resetn = 1'b1;
    hi     = (pll_reset === 1'b1) ? 1 : 0;
    div_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (div !== E0) div_ok = 1'b0;
      if (pll_reset !== 1'b1) break;
      hi++;
    end
    $display("boot: pll_reset high %0d cycles", hi);
    check("boot pll_reset width", hi, 5);
    repeat (20) begin
      tick();
      if (div !== E0) div_ok = 1'b0;
    end
    pll_lock = 1'b1;
    k = 0;
    while (k < 40 && clk_ok !== 1'b1) begin
      tick();
      k++;
      if (div !== E0) div_ok = 1'b0;
    end
    $display("boot: clk_ok %0d cycles after lock", k);
    check("boot lock->clk_ok", k, 10);
    check("boot sys_resetn", sys_resetn, 1);
    check("boot dividers entry0", div_ok, 1);
    check("boot busy", busy, 0);
    check("boot req_ready", req_ready, 1);

    // Request table: bad index, valid change, ignored request while busy
    for (int i = 0; i < 6; i++) begin
      req_valid  = vecs[i].req_valid;
      req_preset = vecs[i].req_preset;
      tick();
      $display("vec %0d: valid=%0b preset=%0d ready=%0b bad=%0b busy=%0b prst=%0b div=%05h act=%0d",
               i, vecs[i].req_valid, vecs[i].req_preset, req_ready, bad_req, busy, pll_reset,
               div, active_preset);
      check($sformatf("vec%0d req_ready", i), req_ready, vecs[i].exp_ready);
      check($sformatf("vec%0d bad_req", i), bad_req, vecs[i].exp_bad);
      check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d pll_reset", i), pll_reset, vecs[i].exp_pll_reset);
      check($sformatf("vec%0d dividers", i), div, vecs[i].exp_div);
      check($sformatf("vec%0d active", i), active_preset, vecs[i].exp_active);
    end
    req_valid = 1'b0;
    wait_run("relock preset2", 40);
    check("preset2 active", active_preset, 2);
    check("preset2 dividers", div, E2);
    check("preset2 busy", busy, 0);

    // One-cycle lock drop in RUN
    pll_lock = 1'b0;
    k = 0;
    while (k < 6) begin
      tick();
      k++;
      if (k == 1) pll_lock = 1'b1;
      if (sys_resetn !== 1'b1) break;
    end
    $display("lockdrop: sys_resetn low after %0d cycles", k);
    check("lockdrop sys_resetn within 3", (sys_resetn === 1'b0 && k <= 3) ? 1 : 0, 1);
    check("lockdrop clk_ok", clk_ok, 0);
    check("lockdrop loss count", lock_loss_cnt, 1);
    saw = 1'b0;
    k = 0;
    while (k < 60 && clk_ok !== 1'b1) begin
      tick();
      k++;
      if (pll_reset === 1'b1) saw = 1'b1;
    end
    check("lockdrop resequence pll_reset", saw, 1);
    check("lockdrop relock", clk_ok, 1);
    check("lockdrop active", active_preset, 2);
    check("lockdrop dividers", div, E2);

    // Preset 3 never locks: two timeouts then fallback to entry 0
    req_preset = 3'd3;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    pll_lock  = 1'b0;
    check("p3 accepted pll_reset", pll_reset, 1);
    for (int a = 0; a < 2; a++) begin
      k = 0;
      while (k < 20 && pll_reset !== 1'b0) begin
        tick();
        k++;
      end
      check($sformatf("p3 try%0d dividers", a), div, E3);
      check($sformatf("p3 try%0d err_fallback", a), err_fallback, 0);
      lo = 1;
      for (int i = 0; i < 200; i++) begin
        tick();
        if (pll_reset !== 1'b0) break;
        lo++;
      end
      $display("p3 try%0d: waited %0d cycles for lock", a, lo);
      check($sformatf("p3 try%0d timeout", a), lo, 100);
    end
    tick();
    tick();
    check("fallback dividers", div, E0);
    check("fallback active", active_preset, 0);
    check("fallback err_fallback", err_fallback, 1);
    pll_lock = 1'b1;
    wait_run("relock fallback", 60);
    check("fallback sticky", err_fallback, 1);
    check("fallback loss count", lock_loss_cnt, 1);

    // Lock glitch in STABLE -> retry same preset, then reset mid-HOLD
    req_preset = 3'd1;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    pll_lock  = 1'b0;
    k = 0;
    while (k < 20 && pll_reset !== 1'b0) begin
      tick();
      k++;
    end
    pll_lock = 1'b1;
    repeat (5) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    saw = 1'b0;
    k = 0;
    while (k < 10 && pll_reset !== 1'b1) begin
      tick();
      k++;
      if (clk_ok === 1'b1) saw = 1'b1;
    end
    $display("glitch: pll_reset back high after %0d cycles", k);
    check("glitch pll_reset", pll_reset, 1);
    check("glitch no clk_ok", saw, 0);
    tick();
    tick();
    check("retry dividers", div, E1);
    check("retry active", active_preset, 1);
    check("retry busy", busy, 1);
    tick();
    tick();
    resetn = 1'b0;
    #1;
    check("midhold pll_reset", pll_reset, 1);
    check("midhold dividers", div, E0);
    check("midhold active", active_preset, 0);
    check("midhold err_fallback", err_fallback, 0);
    check("midhold loss count", lock_loss_cnt, 0);
    check("midhold busy", busy, 1);
    check("midhold req_ready", req_ready, 0);
    check("midhold sys_resetn", sys_resetn, 0);
    check("midhold clk_ok", clk_ok, 0);
    resetn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
